// File: rtl/im_loader_if.sv
// Loader-facing bundle: inbound byte stream, IM write port and core-control status.
// The loader drives the slave side; the stream source and consumers of the outputs use the master side.
interface im_loader_if #(
  parameter int AW = 10
);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;

  modport slave (
    input  in_valid, in_data,
    output in_ready, im_we, im_addr, im_wdata, cpu_hold, done, err
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, im_we, im_addr, im_wdata, cpu_hold, done, err
  );
endinterface

// File: rtl/im_loader.sv
// Framed byte-stream loader for the instruction memory; one IM write a cycle after each 4th data byte.
// Status updates a cycle after the checksum byte; in_ready is always high, so there is no backpressure.
module im_loader #(
  parameter int          AW      = 10,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  im_loader_if.slave io_bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [15:0] LEN_MAX = 16'(1 << AW);
  localparam logic [7:0]  MAGIC   = 8'hA5;

  state_t        r_state;
  state_t        w_next;
  logic [7:0]    r_len_lo;
  logic [AW:0]   r_len;
  logic [AW:0]   r_idx;
  logic [1:0]    r_bcnt;
  logic [23:0]   r_asm;
  logic [7:0]    r_csum;
  logic [15:0]   r_idle;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;

  logic          w_acc;
  logic          w_magic;
  logic [15:0]   w_len16;
  logic [AW:0]   w_idx_inc;
  logic          w_active;
  logic          w_tmo;

  assign w_acc     = io_bus.in_valid;
  assign w_magic   = w_acc && (io_bus.in_data == MAGIC);
  assign w_len16   = {io_bus.in_data, r_len_lo};
  assign w_idx_inc = r_idx + 1'b1;
  assign w_active  = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                     (r_state == S_DATA)   || (r_state == S_CSUM);
  // Fires on the TIMEOUT-th idle edge after the last accepted byte.
  assign w_tmo     = w_active && !w_acc && (r_idle == TIMEOUT - 16'd1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (w_magic) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (w_acc) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (w_acc) begin
          if (w_len16 > LEN_MAX)     w_next = S_ERR;
          else if (w_len16 == 16'd0) w_next = S_CSUM;
          else                       w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_acc && (r_bcnt == 2'd3) && (w_idx_inc == r_len)) w_next = S_CSUM;
      end
      S_CSUM: begin
        if (w_acc) w_next = (io_bus.in_data == r_csum) ? S_DONE : S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_tmo) w_next = S_ERR;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len_lo <= '0;
      r_len    <= '0;
      r_idx    <= '0;
      r_bcnt   <= '0;
      r_asm    <= '0;
      r_csum   <= '0;
      r_idle   <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_active && !w_acc) r_idle <= r_idle + 16'd1;
      else                    r_idle <= '0;

      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (w_magic) begin
            r_csum <= '0;
            r_idx  <= '0;
            r_bcnt <= '0;
          end
        end
        S_LEN_LO: begin
          if (w_acc) r_len_lo <= io_bus.in_data;
        end
        S_LEN_HI: begin
          if (w_acc) r_len <= w_len16[AW:0];
        end
        S_DATA: begin
          if (w_acc) begin
            r_asm  <= {r_asm[15:0], io_bus.in_data};
            r_csum <= r_csum ^ io_bus.in_data;
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              r_we    <= 1'b1;
              r_addr  <= r_idx[AW-1:0];
              r_wdata <= {r_asm, io_bus.in_data};
              r_idx   <= w_idx_inc;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign io_bus.in_ready = 1'b1;
  assign io_bus.im_we    = r_we;
  assign io_bus.im_addr  = r_addr;
  assign io_bus.im_wdata = r_wdata;
  assign io_bus.cpu_hold = (r_state != S_DONE);
  assign io_bus.done     = (r_state == S_DONE);
  assign io_bus.err      = (r_state == S_ERR);

endmodule
